// File: rtl/fdt16_pkg.sv
// Shared definitions for the fdt16 instruction memory: width defaults and loader FSM states.
package fdt16_pkg;

  localparam int FDT16_DATA_W = 16;
  localparam int FDT16_ADDR_W = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM with a registered read port. Contents are not reset.
module imem_ram #(
  parameter int WIDTH = 16,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic             i_re,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [2**AW];
  logic [WIDTH-1:0] r_rdata;

  // Write on we; registered read on re (the caller never asserts both).
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory with burst program loader for the fdt16 CPU.
// Optional build macro INSTR_MEM_PARITY_EN adds a stored even-parity bit
// per word and a parity_err output on the fetch path.
module instr_mem_ctrl
  import fdt16_pkg::*;
#(
  parameter int DATA_W = FDT16_DATA_W,
  parameter int ADDR_W = FDT16_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_count,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              load_busy,
  output logic              load_done,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr_out,
`ifdef INSTR_MEM_PARITY_EN
  output logic              parity_err,
`endif
  output logic              instr_valid
);

`ifdef INSTR_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  ld_state_e         r_state;
  ld_state_e         w_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   r_rem;
  logic              r_instr_valid;
  logic              w_beat;
  logic              w_fetch;
  logic              w_start_load;
  logic              w_ld_ready;
  logic              w_busy;
  logic              w_done;
  logic [ADDR_W-1:0] w_addr;
  logic [MEM_W-1:0]  w_wdata;
  logic [MEM_W-1:0]  w_rdata;

  assign w_beat       = (r_state == LOAD) && ld_valid;
  assign w_fetch      = fetch_req && (r_state != LOAD);
  assign w_start_load = (r_state == IDLE) && load_start && (load_count != '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic: a zero-length burst goes straight to DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (load_start) w_next = (load_count != '0) ? LOAD : DONE;
      LOAD: if (w_beat && (r_rem == {{ADDR_W{1'b0}}, 1'b1})) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State-decoded handshake/status outputs.
  always_comb begin
    w_ld_ready = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    case (r_state)
      LOAD: begin
        w_ld_ready = 1'b1;
        w_busy     = 1'b1;
      end
      DONE: w_done = 1'b1;
      default: ;
    endcase
  end

  // Write pointer and remaining-beat counter; pointer wraps at the top of memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
      r_rem <= '0;
    end else if (w_start_load) begin
      r_ptr <= load_base;
      r_rem <= load_count;
    end else if (w_beat) begin
      r_ptr <= r_ptr + {{(ADDR_W-1){1'b0}}, 1'b1};
      r_rem <= r_rem - {{ADDR_W{1'b0}}, 1'b1};
    end
  end

  // Fetch valid tracks the RAM's one-cycle read latency; fetches in LOAD are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_instr_valid <= 1'b0;
    else        r_instr_valid <= w_fetch;
  end

  // Single port is shared: writes only happen in LOAD, where fetches are blocked.
  assign w_addr = w_beat ? r_ptr : pc;

`ifdef INSTR_MEM_PARITY_EN
  assign w_wdata = {^ld_data, ld_data};
`else
  assign w_wdata = ld_data;
`endif

  imem_ram #(
    .WIDTH (MEM_W),
    .AW    (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_beat),
    .i_re    (w_fetch),
    .i_addr  (w_addr),
    .i_wdata (w_wdata),
    .o_rdata (w_rdata)
  );

  assign ld_ready    = w_ld_ready;
  assign load_busy   = w_busy;
  assign load_done   = w_done;
  assign instr_valid = r_instr_valid;
  assign instr_out   = r_instr_valid ? w_rdata[DATA_W-1:0] : '0;

`ifdef INSTR_MEM_PARITY_EN
  // Stored word plus parity bit must XOR to zero; flag any mismatch on a valid fetch.
  assign parity_err = r_instr_valid && (^w_rdata);
`endif

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed self-checking bench for instr_mem_ctrl.
module tb_instr_mem_ctrl;
  localparam int DW = 16;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load_start;
  logic [AW-1:0] load_base;
  logic [AW:0]   load_count;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          load_busy;
  logic          load_done;
  logic          fetch_req;
  logic [AW-1:0] pc;
  logic [DW-1:0] instr_out;
  logic          instr_valid;
`ifdef INSTR_MEM_PARITY_EN
  logic          parity_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_start  (load_start),
    .load_base   (load_base),
    .load_count  (load_count),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .fetch_req   (fetch_req),
    .pc          (pc),
    .instr_out   (instr_out),
`ifdef INSTR_MEM_PARITY_EN
    .parity_err  (parity_err),
`endif
    .instr_valid (instr_valid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; registered outputs are then settled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fetch one address and check the word returned on the next cycle.
  task automatic fetch_chk(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    fetch_req = 1'b1;
    pc        = a;
    tick();
    fetch_req = 1'b0;
    chk({tag, "_vld"}, {31'd0, instr_valid}, 32'd1);
    chk(tag, {16'd0, instr_out}, {16'd0, exp});
  endtask

  task automatic start_load(input logic [AW-1:0] b, input logic [AW:0] c);
    load_start = 1'b1;
    load_base  = b;
    load_count = c;
    tick();
    load_start = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d);
    ld_valid = 1'b1;
    ld_data  = d;
    tick();
    ld_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_start = 1'b0; load_base = '0; load_count = '0;
    ld_valid = 1'b0; ld_data = '0; fetch_req = 1'b0; pc = '0;
    tick();
    // Reset state
    chk("rst_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_busy",  {31'd0, load_busy}, 32'd0);
    chk("rst_done",  {31'd0, load_done}, 32'd0);
    chk("rst_ivld",  {31'd0, instr_valid}, 32'd0);
    chk("rst_iout",  {16'd0, instr_out}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic load of three words at 0x010
    start_load(10'h010, 11'd3);
    chk("b_busy",  {31'd0, load_busy}, 32'd1);
    chk("b_ready", {31'd0, ld_ready}, 32'd1);
    ld_valid = 1'b1;
    ld_data = 16'hA001; tick();
    ld_data = 16'hA002; tick();
    ld_data = 16'hA003; tick();
    ld_valid = 1'b0;
    chk("b_done",  {31'd0, load_done}, 32'd1);
    chk("b_dbusy", {31'd0, load_busy}, 32'd0);
    chk("b_dready",{31'd0, ld_ready}, 32'd0);
    // fetch issued in the DONE cycle sees the last word
    fetch_chk("b_f12", 10'h012, 16'hA003);
    chk("b_done_clr", {31'd0, load_done}, 32'd0);
    fetch_chk("b_f10", 10'h010, 16'hA001);
    fetch_chk("b_f11", 10'h011, 16'hA002);
    tick();
    chk("idle_ivld", {31'd0, instr_valid}, 32'd0);
    chk("idle_iout", {16'd0, instr_out}, 32'd0);

    // Backpressure: valid pattern 1,0,0,1,0,1 and a dropped fetch mid-burst
    start_load(10'h020, 11'd3);
    beat(16'hB001);
    chk("s_busy1", {31'd0, load_busy}, 32'd1);
    ld_data = 16'hFFFF; fetch_req = 1'b1; pc = 10'h010;
    tick();
    fetch_req = 1'b0;
    chk("s_drop_vld", {31'd0, instr_valid}, 32'd0);
    chk("s_drop_out", {16'd0, instr_out}, 32'd0);
    chk("s_busy2", {31'd0, load_busy}, 32'd1);
    tick();
    chk("s_busy3", {31'd0, load_busy}, 32'd1);
    beat(16'hB002);
    chk("s_busy4", {31'd0, load_busy}, 32'd1);
    tick();
    chk("s_busy5", {31'd0, load_busy}, 32'd1);
    beat(16'hB003);
    chk("s_done", {31'd0, load_done}, 32'd1);
    tick();
    fetch_chk("s_f20", 10'h020, 16'hB001);
    fetch_chk("s_f21", 10'h021, 16'hB002);
    fetch_chk("s_f22", 10'h022, 16'hB003);

    // Wrap-around past the top address
    start_load(10'h3FE, 11'd4);
    beat(16'h1111); beat(16'h2222); beat(16'h3333); beat(16'h4444);
    chk("w_done", {31'd0, load_done}, 32'd1);
    tick();
    fetch_chk("w_3fe", 10'h3FE, 16'h1111);
    fetch_chk("w_3ff", 10'h3FF, 16'h2222);
    fetch_chk("w_000", 10'h000, 16'h3333);
    fetch_chk("w_001", 10'h001, 16'h4444);

    // Zero-length burst: DONE immediately, nothing written
    start_load(10'h010, 11'd0);
    chk("z_done", {31'd0, load_done}, 32'd1);
    chk("z_busy", {31'd0, load_busy}, 32'd0);
    tick();
    chk("z_done_clr", {31'd0, load_done}, 32'd0);
    fetch_chk("z_f10", 10'h010, 16'hA001);

    // load_start during LOAD is ignored
    start_load(10'h030, 11'd2);
    load_start = 1'b1; load_base = 10'h040; load_count = 11'd5;
    beat(16'hC001);
    load_start = 1'b0;
    chk("i_busy", {31'd0, load_busy}, 32'd1);
    beat(16'hC002);
    chk("i_done", {31'd0, load_done}, 32'd1);
    tick();
    fetch_chk("i_f30", 10'h030, 16'hC001);
    fetch_chk("i_f31", 10'h031, 16'hC002);

    // Reset in the middle of a burst
    start_load(10'h050, 11'd5);
    beat(16'hD001); beat(16'hD002);
    rst_n = 1'b0;
    #2;
    chk("r_busy",  {31'd0, load_busy}, 32'd0);
    chk("r_ready", {31'd0, ld_ready}, 32'd0);
    chk("r_done",  {31'd0, load_done}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("r_done2", {31'd0, load_done}, 32'd0);
    chk("r_busy2", {31'd0, load_busy}, 32'd0);
    fetch_chk("r_f50", 10'h050, 16'hD001);
    fetch_chk("r_f51", 10'h051, 16'hD002);

`ifdef INSTR_MEM_PARITY_EN
    // Corrupt the stored parity bit of one word; the neighbour stays clean
    start_load(10'h060, 11'd2);
    beat(16'h0003); beat(16'h0007);
    tick();
    u_dut.u_ram.r_mem[10'h060][DW] = ~u_dut.u_ram.r_mem[10'h060][DW];
    fetch_chk("p_f60", 10'h060, 16'h0003);
    chk("p_err60", {31'd0, parity_err}, 32'd1);
    fetch_chk("p_f61", 10'h061, 16'h0007);
    chk("p_err61", {31'd0, parity_err}, 32'd0);
    tick();
    chk("p_err_idle", {31'd0, parity_err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
Name: instr_mem_ctrl

Overview:
Parametrised instruction memory for the fdt16 CPU with a built-in program loader.
- CPU fetches through a synchronous, registered read port with a valid flag.
- An external loader streams a program burst over a valid/ready handshake into a base address, with auto-increment.
- While a load is in progress the block reports busy so the core can stall.

Parameters:
DATA_W, 16, instruction word width
ADDR_W, 10, address width; depth is 2**ADDR_W words

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
load_start  in  1  pulse: begin a load burst (sampled in IDLE only)
load_base  in  ADDR_W  first write address of the burst, sampled with load_start
load_count  in  ADDR_W+1  number of words to write, 0..2**ADDR_W, sampled with load_start
ld_valid  in  1  loader data valid
ld_data  in  DATA_W  loader data word
ld_ready  out  1  block accepts ld_data this cycle
load_busy  out  1  high in LOAD state
load_done  out  1  one-cycle pulse when a burst completes
fetch_req  in  1  CPU fetch request
pc  in  ADDR_W  fetch address
instr_out  out  DATA_W  fetched instruction
instr_valid  out  1  instr_out valid this cycle

Behaviour:
- Reset (async assert, sync release): state=IDLE, ld_ready=0, load_busy=0, load_done=0, instr_valid=0, instr_out=0, write pointer and remaining count = 0. Memory contents are not reset.
- FSM states: IDLE, LOAD, DONE.
- IDLE transitions:
  - load_start with load_count>0: latch ptr=load_base, remaining=load_count, go to LOAD.
  - load_start with load_count==0: go directly to DONE; no writes.
- LOAD:
  - ld_ready=1 and load_busy=1.
  - A beat occurs on ld_valid&&ld_ready: mem[ptr]<=ld_data, ptr<=ptr+1 mod 2**ADDR_W (wraps past top), remaining<=remaining-1.
  - The beat with remaining==1 moves the FSM to DONE.
  - ld_valid low stalls indefinitely; no timeout.
- DONE: lasts one cycle with load_done=1, ld_ready=0, busy=0, then returns to IDLE.
- load_start outside IDLE is ignored.
- Fetch path:
  - Latency is one cycle. fetch_req=1 with state!=LOAD at cycle N gives instr_out=mem[pc] and instr_valid=1 at N+1.
  - Otherwise instr_valid=0 at N+1 and instr_out=0.
  - fetch_req during LOAD is dropped (not queued); the CPU must hold or retry.
- Fetch in the DONE cycle is accepted and sees every word written by the burst. The last write lands on the edge entering DONE.
- No read/write collision is possible: writes occur only in LOAD, where fetches are blocked.
- Reset mid-burst: FSM returns to IDLE, no load_done pulse, and already-written words remain in memory.
- load_count==2**ADDR_W overwrites the whole memory exactly once.

Optional Feature:
Macro INSTR_MEM_PARITY_EN.
- Defined:
  - Memory stores DATA_W+1 bits per word; the extra bit is even parity of ld_data, computed on write.
  - Adds output port parity_err (1 bit, reset 0). It is asserted alongside instr_valid when the stored word's parity mismatches, and is 0 otherwise.
  - Data is still delivered unmodified.
- Not defined: no extra storage bit and no parity_err port.

Decomposition:
- Shared package fdt16_pkg:
  - DATA_W and ADDR_W defaults.
  - FSM state enum (IDLE/LOAD/DONE, 2-bit).
- Sub-module imem_ram: single-port synchronous RAM with write enable, registered read, width DATA_W(+1), depth 2**ADDR_W. The FSM and fetch gating stay in instr_mem_ctrl.

Test Plan:
- Reset/basic load: assert rst_n=0 and check all outputs are 0. Load base=0x010, count=3, data 0xA001,0xA002,0xA003 with ld_valid held high → load_done one cycle after the 3rd beat. Fetches of pc=0x010..0x012 return those words one cycle later with instr_valid=1.
- Backpressure/stall: same load with ld_valid toggling 1,0,0,1,0,1 → exactly 3 writes, load_busy high throughout. fetch_req during LOAD → instr_valid=0 and instr_out=0 next cycle.
- Wrap-around: base=0x3FE, count=4, data 0x1111..0x4444 → mem[0x3FE]=0x1111, mem[0x3FF]=0x2222, mem[0x000]=0x3333, mem[0x001]=0x4444.
- Zero count and ignored start: load_count=0 → load_done one cycle after load_start, memory unchanged. load_start asserted mid-LOAD → no effect on ptr or count.
- Reset mid-burst: count=5; pull rst_n low after 2 beats → IDLE, no load_done. After release, fetches of the first 2 addresses return the written data.
- Parity (INSTR_MEM_PARITY_EN): load 0x0003, force the stored parity bit to flip, fetch → parity_err=1 and instr_out=0x0003. Fetch of an untouched, correctly written word → parity_err=0.
